// File: rtl/dual_port_memory_arbiter.sv
// Round-robin arbiter between two cache miss ports and a single-ported 16-bit word memory.
// Byte reads/writes return the full aligned word; a hung memory is released by an ack timeout.
`timescale 1ns/1ps
module dual_port_memory_arbiter #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [24:0] memory_request_0,
  input  logic        memory_request_ready_0,
  input  logic [24:0] memory_request_1,
  input  logic        memory_request_ready_1,
  output logic [15:0] memory_response_0,
  output logic        memory_response_ready_0,
  output logic [15:0] memory_response_1,
  output logic        memory_response_ready_1,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [1:0]  mem_byte_en,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        timeout_flag
);

  localparam logic [7:0] ACK_LIMIT = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t      state, state_next;
  logic        grant, grant_next, last_grant;
  logic [1:0]  ready_q, slot_full, capture;
  logic [24:0] slot_req_0, slot_req_1, sel_req;
  logic [7:0]  ack_count;
  logic [15:0] word_q;
  logic        ack_done, ack_expired;

  // A slot only reloads on a fresh rising edge once the previous response has been released.
  assign capture[0] = memory_request_ready_0 & ~ready_q[0] & ~slot_full[0] & ~memory_response_ready_0;
  assign capture[1] = memory_request_ready_1 & ~ready_q[1] & ~slot_full[1] & ~memory_response_ready_1;
  assign sel_req    = grant ? slot_req_1 : slot_req_0;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_next  = state;
    grant_next  = grant;
    ack_done    = 1'b0;
    ack_expired = 1'b0;
    case (state)
      ST_IDLE: begin
        if (slot_full != 2'b00) begin
          grant_next = (slot_full == 2'b11) ? ~last_grant : slot_full[1];
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (mem_ack) begin
          ack_done   = 1'b1;
          state_next = ST_RESP;
        end else if (ack_count == ACK_LIMIT) begin
          ack_expired = 1'b1;
          state_next  = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      grant <= grant_next;
      if (state == ST_IDLE && state_next == ST_ISSUE) last_grant <= grant_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_q    <= 2'b00;
      slot_full  <= 2'b00;
      slot_req_0 <= '0;
      slot_req_1 <= '0;
    end else begin
      ready_q <= {memory_request_ready_1, memory_request_ready_0};
      if (capture[0]) begin
        slot_full[0] <= 1'b1;
        slot_req_0   <= memory_request_0;
      end
      if (capture[1]) begin
        slot_full[1] <= 1'b1;
        slot_req_1   <= memory_request_1;
      end
      if (state == ST_RESP) slot_full[grant] <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_byte_en  <= 2'b00;
      mem_wdata    <= '0;
      ack_count    <= '0;
      word_q       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        ST_ISSUE: begin
          mem_req     <= 1'b1;
          mem_we      <= sel_req[24];
          mem_addr    <= sel_req[15:1];
          mem_wdata   <= {sel_req[23:16], sel_req[23:16]};
          mem_byte_en <= sel_req[24] ? (sel_req[0] ? 2'b10 : 2'b01) : 2'b00;
          ack_count   <= '0;
        end
        ST_WAIT: begin
          if (ack_done || ack_expired) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_byte_en <= 2'b00;
            mem_wdata   <= '0;
            ack_count   <= '0;
            word_q      <= ack_done ? mem_rdata : 16'h0000;
            if (ack_expired) timeout_flag <= 1'b1;
          end else begin
            ack_count <= ack_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Loading a response wins over releasing it, so an early-dropped request still sees one pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      memory_response_0       <= '0;
      memory_response_ready_0 <= 1'b0;
      memory_response_1       <= '0;
      memory_response_ready_1 <= 1'b0;
    end else begin
      if (state == ST_RESP && !grant) begin
        memory_response_0       <= word_q;
        memory_response_ready_0 <= 1'b1;
      end else if (memory_response_ready_0 && !memory_request_ready_0) begin
        memory_response_0       <= '0;
        memory_response_ready_0 <= 1'b0;
      end
      if (state == ST_RESP && grant) begin
        memory_response_1       <= word_q;
        memory_response_ready_1 <= 1'b1;
      end else if (memory_response_ready_1 && !memory_request_ready_1) begin
        memory_response_1       <= '0;
        memory_response_ready_1 <= 1'b0;
      end
    end
  end

endmodule
